// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  // Fetch FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage and memory.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  // Fetch stage side.
  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  // Memory side.
  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry {pc, instr} skid buffer; clear wins over load.
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] instr_d, instr_q;

  // Next-state: clear empties the entry, load captures a new one.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = XLEN'(NopInstr);
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  // Entry registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= XLEN'(NopInstr);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// parks one instruction in a skid entry while ID stalls, and drives IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned XLEN     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fetch_stage_if.master    imem,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic             if_id_valid_o,
  output logic [XLEN-1:0]  if_id_pc_o,
  output logic [XLEN-1:0]  if_id_instr_o
);

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  // Address of a squashed request that must still complete.
  logic [XLEN-1:0] drain_addr_d, drain_addr_q;
  logic            if_id_valid_d, if_id_valid_q;
  logic [XLEN-1:0] if_id_pc_d, if_id_pc_q;
  logic [XLEN-1:0] if_id_instr_d, if_id_instr_q;

  logic            skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;
  logic            xfer;

  // Request is a pure decode of the state flop, so it never glitches.
  assign imem.req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem.addr = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign xfer      = imem.req && imem.ack;

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (imem.rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Next-state for FSM, PC and IF/ID; flush overrides everything at the end.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (xfer) begin
          pc_d = pc_q + XLEN'(4);
          if (stall_i) begin
            skid_load = 1'b1;
            state_d   = StHold;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem.rdata;
          end
        end
      end
      StHold: begin
        if (!stall_i) begin
          if_id_valid_d = skid_valid;
          if_id_pc_d    = skid_pc;
          if_id_instr_d = skid_instr;
          skid_clear    = 1'b1;
          state_d       = StFetch;
        end
      end
      StDrain: begin
        // Squashed data is dropped; resume at the (redirected) pc.
        if (imem.ack) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush_i) begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = '0;
      if_id_instr_d = XLEN'(NopInstr);
      skid_load     = 1'b0;
      skid_clear    = 1'b1;
      pc_d          = {branch_target_i[XLEN-1:2], 2'b00};
      unique case (state_q)
        StFetch: begin
          if (imem.ack) begin
            state_d = StFetch;
          end else begin
            // Outstanding request must complete before redirecting.
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end
        end
        StHold: begin
          state_d = StFetch;
        end
        // StDrain keeps its ack-driven exit; StIdle still goes to StFetch.
        default: ;
      endcase
    end
  end

  // All FSM, PC and IF/ID state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= StIdle;
      pc_q          <= XLEN'(RESET_PC);
      drain_addr_q  <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= XLEN'(NopInstr);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign if_id_valid_o = if_id_valid_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;

endmodule
